// File: rtl/huffman_pkg.sv
// Shared constants, FSM state type and length check for the Huffman byte scheduler.
package huffman_pkg;

  localparam int unsigned BLK_BYTES = 20;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned LEN_W     = 5;
  localparam int unsigned BLK_W     = BLK_BYTES * BYTE_W;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A block must carry at least one byte and no more than it can hold.
  function automatic logic is_legal_len(input logic [LEN_W-1:0] len);
    return (len != '0) && (32'(len) <= BLK_BYTES);
  endfunction

endpackage

// File: rtl/huffman_buffer_sched_if.sv
// Requester, output stream and status signals of the Huffman byte scheduler.
interface huffman_buffer_sched_if;
  import huffman_pkg::*;

  logic              req0_valid;
  logic [BLK_W-1:0]  req0_data;
  logic [LEN_W-1:0]  req0_len;
  logic              req0_ready;
  logic              req1_valid;
  logic [BLK_W-1:0]  req1_data;
  logic [LEN_W-1:0]  req1_len;
  logic              req1_ready;
  logic              out_valid;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic              out_src;
  logic              out_ready;
  logic              len_err;
  logic [CNT_W-1:0]  blk_cnt;

  modport master (
    output req0_valid, req0_data, req0_len,
    output req1_valid, req1_data, req1_len,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_last, out_src,
    input  len_err, blk_cnt
  );

  modport slave (
    input  req0_valid, req0_data, req0_len,
    input  req1_valid, req1_data, req1_len,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_last, out_src,
    output len_err, blk_cnt
  );

endinterface

// File: rtl/huffman_rr_arb2.sv
// Two-way round-robin arbiter: prio picks the winner only when both request.
module huffman_rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] grant_c,
  output logic       prio_next_c
);

  always_comb begin
    grant_c     = 2'b00;
    prio_next_c = prio;
    if (en) begin
      if (req == 2'b11) begin
        grant_c = prio ? 2'b10 : 2'b01;
      end else begin
        grant_c = req;
      end
    end
    // The loser of this round gets priority next time.
    if (grant_c[0]) begin
      prio_next_c = 1'b1;
    end else if (grant_c[1]) begin
      prio_next_c = 1'b0;
    end
  end

endmodule

// File: rtl/huffman_buffer_sched.sv
// Round-robin capture of 20-byte blocks from two producers, streamed LSB-first
// to the Huffman encoder under valid/ready.
module huffman_buffer_sched
  import huffman_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  huffman_buffer_sched_if.slave bus
);

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic [BLK_W-1:0]  data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [BYTE_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_src_q, out_src_d;
  logic              len_err_q, len_err_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

  logic              arb_en_c;
  logic [1:0]        grant_c;
  logic              prio_next_c;
  logic [BLK_W-1:0]  sel_data_c;
  logic [LEN_W-1:0]  sel_len_c;
  logic [LEN_W-1:0]  idx_inc_c;

  function automatic logic [BYTE_W-1:0] byte_at(input logic [BLK_W-1:0] d,
                                                input logic [LEN_W-1:0] i);
    return BYTE_W'(d >> (BYTE_W * i));
  endfunction

  // Requesters are only served from IDLE and never while reset is held.
  assign arb_en_c = (state_q == IDLE) && !reset;

  huffman_rr_arb2 u_arb (
    .req         ({bus.req1_valid, bus.req0_valid}),
    .prio        (prio_q),
    .en          (arb_en_c),
    .grant_c     (grant_c),
    .prio_next_c (prio_next_c)
  );

  assign sel_data_c = grant_c[1] ? bus.req1_data : bus.req0_data;
  assign sel_len_c  = grant_c[1] ? bus.req1_len  : bus.req0_len;
  assign idx_inc_c  = idx_q + LEN_W'(1);

  assign bus.req0_ready = grant_c[0];
  assign bus.req1_ready = grant_c[1];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_src    = out_src_q;
  assign bus.len_err    = len_err_q;
  assign bus.blk_cnt    = blk_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
      len_err_q   <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      data_q      <= data_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      len_err_q   <= len_err_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  // Next-state and next-output logic; the presented byte is preloaded one step ahead.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    data_d      = data_q;
    len_d       = len_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    len_err_d   = 1'b0;
    blk_cnt_d   = blk_cnt_q;

    case (state_q)
      IDLE: begin
        if (|grant_c) begin
          prio_d = prio_next_c;
          if (is_legal_len(sel_len_c)) begin
            data_d      = sel_data_c;
            len_d       = sel_len_c;
            idx_d       = '0;
            out_src_d   = grant_c[1];
            out_valid_d = 1'b1;
            out_data_d  = byte_at(sel_data_c, '0);
            out_last_d  = (sel_len_c == LEN_W'(1));
            state_d     = SEND;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            blk_cnt_d   = blk_cnt_q + CNT_W'(1);
            state_d     = IDLE;
          end else begin
            idx_d      = idx_inc_c;
            out_data_d = byte_at(data_q, idx_inc_c);
            out_last_d = (idx_inc_c == len_q - LEN_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_huffman_buffer_sched.sv
// Randomised and directed bench for huffman_buffer_sched against a queue-based model.
module tb_huffman_buffer_sched;
  import huffman_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  huffman_buffer_sched_if bus ();
  huffman_buffer_sched dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a pending-byte queue for the block in flight plus arbitration state.
  bit          m_busy, m_prio, m_src, m_err;
  logic [15:0] m_cnt;
  logic [7:0]  m_q[$];

  // Observation logs used by the directed literal checks.
  logic [7:0] seen_bytes[$];
  bit         seen_last[$];
  int         grants[$];
  int         n_err_seen, n_valid_seen, step_no, accept_step, last_hs_step;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit legal(input logic [4:0] l);
    return (l >= 5'd1) && (l <= 5'd20);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_prio = 0; m_src = 0; m_err = 0; m_cnt = 16'h0;
    m_q.delete();
  endtask

  task automatic clear_logs();
    seen_bytes.delete(); seen_last.delete(); grants.delete();
    n_err_seen = 0; n_valid_seen = 0; last_hs_step = -1;
  endtask

  task automatic check_reset_vals();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_src", 32'(bus.out_src), 32'd0);
    check("rst_len_err", 32'(bus.len_err), 32'd0);
    check("rst_blk_cnt", 32'(bus.blk_cnt), 32'd0);
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // One clock: drive inputs, compare every output with the model, then advance the model.
  task automatic step(input bit v0, input logic [159:0] d0, input logic [4:0] l0,
                      input bit v1, input logic [159:0] d1, input logic [4:0] l1,
                      input bit ordy);
    int g;
    logic [159:0] d;
    logic [4:0]   l;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_len = l0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_len = l1;
    bus.out_ready  = ordy;
    #1;
    step_no++;
    g = -1;
    if (!m_busy && (v0 || v1)) g = (v0 && v1) ? int'(m_prio) : (v1 ? 1 : 0);

    check("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
    check("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
    check("out_valid", 32'(bus.out_valid), 32'(m_busy));
    if (m_busy) begin
      check("out_data", 32'(bus.out_data), 32'(m_q[0]));
      check("out_last", 32'(bus.out_last), 32'(m_q.size() == 1));
      check("out_src", 32'(bus.out_src), 32'(m_src));
    end
    check("len_err", 32'(bus.len_err), 32'(m_err));
    check("blk_cnt", 32'(bus.blk_cnt), 32'(m_cnt));

    if (bus.out_valid && ordy) begin
      seen_bytes.push_back(bus.out_data);
      seen_last.push_back(bus.out_last);
      if (bus.out_last) last_hs_step = step_no;
    end
    if (bus.req0_ready && v0) grants.push_back(0);
    if (bus.req1_ready && v1) grants.push_back(1);
    n_err_seen   += int'(bus.len_err);
    n_valid_seen += int'(bus.out_valid);

    m_err = 0;
    if (g >= 0) begin
      m_prio = (g == 0);
      d = (g == 1) ? d1 : d0;
      l = (g == 1) ? l1 : l0;
      if (legal(l)) begin
        m_q.delete();
        for (int k = 0; k < int'(l); k++) m_q.push_back(d[8*k +: 8]);
        m_src  = (g == 1);
        m_busy = 1;
      end else begin
        m_err = 1;
      end
    end else if (m_busy && ordy) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 0;
        m_cnt  = m_cnt + 16'd1;
      end
    end
  endtask

  task automatic idle_steps(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, '0, 5'd0, 0, '0, 5'd0, ordy);
  endtask

  logic [159:0] da, db;
  logic [4:0]   la, lb;

  initial begin
    bus.req0_valid = 0; bus.req0_data = '0; bus.req0_len = '0;
    bus.req1_valid = 0; bus.req1_data = '0; bus.req1_len = '0;
    bus.out_ready  = 0;
    step_no = 0;
    clear_logs();
    #2;

    // Basic three-byte block from requester 0.
    do_reset();
    clear_logs();
    da = '0; da[23:0] = 24'h332211;
    step(1, da, 5'd3, 0, '0, 5'd0, 1);
    idle_steps(5, 1);
    check("t1_ready_pulses", 32'(grants.size()), 32'd1);
    check("t1_nbytes", 32'(seen_bytes.size()), 32'd3);
    if (seen_bytes.size() == 3) begin
      check("t1_byte0", 32'(seen_bytes[0]), 32'h11);
      check("t1_byte1", 32'(seen_bytes[1]), 32'h22);
      check("t1_byte2", 32'(seen_bytes[2]), 32'h33);
      check("t1_last", {29'd0, seen_last[0], seen_last[1], seen_last[2]}, 32'b001);
    end
    check("t1_blk_cnt", 32'(bus.blk_cnt), 32'd1);

    // Both requesters saturated: grants alternate starting from 0.
    do_reset();
    clear_logs();
    for (int i = 0; i < 90; i++) step(1, rnd_blk(), 5'd20, 1, rnd_blk(), 5'd20, 1);
    check("t2_ngrants", 32'(grants.size()), 32'd5);
    if (grants.size() >= 4) begin
      check("t2_grant_seq", 32'({grants[0][0], grants[1][0], grants[2][0], grants[3][0]}),
            32'b0101);
    end

    // Full block with out_ready toggling: 20 stalls + 20 transfers + accept.
    do_reset();
    clear_logs();
    da = rnd_blk();
    step(1, da, 5'd20, 0, '0, 5'd0, 0);
    accept_step = step_no;
    for (int i = 0; i < 42; i++) step(0, '0, 5'd0, 0, '0, 5'd0, (i % 2) == 1);
    check("t3_block_cycles", 32'(last_hs_step - accept_step + 1), 32'd41);
    check("t3_nbytes", 32'(seen_bytes.size()), 32'd20);
    if (seen_bytes.size() == 20)
      for (int k = 0; k < 20; k++) check("t3_byte", 32'(seen_bytes[k]), 32'(da[8*k +: 8]));

    // Illegal lengths are dropped with a len_err pulse and still flip priority.
    do_reset();
    clear_logs();
    step(0, '0, 5'd0, 1, rnd_blk(), 5'd0, 1);
    idle_steps(1, 1);
    step(0, '0, 5'd0, 1, rnd_blk(), 5'd21, 1);
    idle_steps(2, 1);
    check("t4_len_err_pulses", 32'(n_err_seen), 32'd2);
    check("t4_no_out_valid", 32'(n_valid_seen), 32'd0);
    check("t4_blk_cnt", 32'(bus.blk_cnt), 32'd0);
    step(1, rnd_blk(), 5'd1, 1, rnd_blk(), 5'd1, 1);
    check("t4_prio_after", 32'(grants[grants.size()-1]), 32'd0);
    idle_steps(3, 1);

    // Reset while byte 7 of a 20-byte block is presented.
    do_reset();
    clear_logs();
    step(1, rnd_blk(), 5'd20, 0, '0, 5'd0, 1);
    idle_steps(7, 1);
    idle_steps(1, 0);
    check("t5_byte_idx_before_rst", 32'(seen_bytes.size()), 32'd7);
    #2;
    bus.req0_valid = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_vals();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    clear_logs();
    db = rnd_blk();
    step(0, '0, 5'd0, 1, db, 5'd4, 1);
    idle_steps(6, 1);
    check("t5_nbytes", 32'(seen_bytes.size()), 32'd4);
    if (seen_bytes.size() == 4) check("t5_first_byte", 32'(seen_bytes[0]), 32'(db[7:0]));

    // blk_cnt wraps from 0xFFFF to 0.
    do_reset();
    idle_steps(1, 1);
    force dut.blk_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.blk_cnt_q;
    m_cnt = 16'hFFFF;
    idle_steps(1, 1);
    step(1, rnd_blk(), 5'd2, 0, '0, 5'd0, 1);
    idle_steps(4, 1);
    check("t6_wrap", 32'(bus.blk_cnt), 32'd0);

    // Randomised traffic, including illegal lengths and back-pressure.
    for (int i = 0; i < 1500; i++) begin
      la = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(21, 31)) & 5'h1F :
           5'($urandom_range(1, 20));
      lb = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 20));
      step($urandom_range(0, 2) != 0, rnd_blk(), la,
           $urandom_range(0, 2) != 0, rnd_blk(), lb,
           $urandom_range(0, 3) != 0);
    end
    idle_steps(25, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
